// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common-data-bus arbiter.
//   ADDR_WIDTH / ROB_WIDTH : default field widths of a CDB result
//   cdb_src_e              : source encoding (SRC_RS = 0, SRC_LSB = 1)
//   cdb_entry_t            : one queued result {rob_index, value, next_pc}
package cdb_arbiter_pkg;

  localparam int unsigned ADDR_WIDTH  = 32;
  localparam int unsigned ROB_WIDTH   = 8;
  localparam int unsigned VALUE_WIDTH = 32;

  typedef enum logic {
    SRC_RS  = 1'b0,
    SRC_LSB = 1'b1
  } cdb_src_e;

  typedef struct packed {
    logic [ROB_WIDTH-1:0]   rob_index;
    logic [VALUE_WIDTH-1:0] value;
    logic [ADDR_WIDTH-1:0]  next_pc;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO for the CDB arbiter.
//   clk, rst : clock, synchronous active-high reset
//   en       : global ready; low freezes all state
//   flush    : discard every queued entry (takes precedence over push/pop)
//   push     : write push_data at the tail
//   pop      : drop the head entry
//   head     : current head entry (valid when !empty)
//   empty    : no entries queued
//   full     : 2**FIFO_DEPTH_LOG entries queued
module cdb_src_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH_LOG = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  cdb_entry_t push_data,
  output cdb_entry_t head,
  output logic       empty,
  output logic       full
);

  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG;

  cdb_entry_t                mem [DEPTH];
  logic [FIFO_DEPTH_LOG-1:0] rd_ptr;
  logic [FIFO_DEPTH_LOG-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG:0]   count;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (en) begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (!rst && en && !flush && push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  // count never exceeds DEPTH, so its MSB is set only when full.
  assign full  = count[FIFO_DEPTH_LOG];

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: two result producers (RS/ALU and LSB) share one
// registered broadcast lane. Each source has a small FIFO behind a
// valid/ready handshake; a round-robin arbiter pops one head per cycle.
//   clk_in, rst_in           : clock, synchronous active-high reset
//   rdy_in                   : global ready; low freezes all state
//   rollback_in              : flush every pending result
//   rs_*_in / rs_ready_out   : RS result handshake and payload
//   lsb_*_in / lsb_ready_out : LSB result handshake and payload (no next PC)
//   cdb_*_out                : registered broadcast; cdb_src_out 0 = RS, 1 = LSB
// Build option: define CDB_ARB_LSB_PRIO_EN for fixed priority (LSB wins every
// conflict, no priority register); otherwise round-robin.
module cdb_arbiter #(
  parameter int unsigned ADDR_WIDTH     = cdb_arbiter_pkg::ADDR_WIDTH,
  parameter int unsigned ROB_WIDTH      = cdb_arbiter_pkg::ROB_WIDTH,
  parameter int unsigned FIFO_DEPTH_LOG = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  rollback_in,
  input  logic                  rs_valid_in,
  output logic                  rs_ready_out,
  input  logic [ROB_WIDTH-1:0]  rs_rob_index_in,
  input  logic [31:0]           rs_value_in,
  input  logic [ADDR_WIDTH-1:0] rs_next_pc_in,
  input  logic                  lsb_valid_in,
  output logic                  lsb_ready_out,
  input  logic [ROB_WIDTH-1:0]  lsb_rob_index_in,
  input  logic [31:0]           lsb_value_in,
  output logic                  cdb_en_out,
  output logic [ROB_WIDTH-1:0]  cdb_rob_index_out,
  output logic [31:0]           cdb_value_out,
  output logic [ADDR_WIDTH-1:0] cdb_next_pc_out,
  output logic                  cdb_src_out
);

  import cdb_arbiter_pkg::*;

  cdb_entry_t rs_push_data, lsb_push_data;
  cdb_entry_t rs_head, lsb_head, grant_entry;
  logic       rs_empty, rs_full, lsb_empty, lsb_full;
  logic       rs_push, lsb_push, rs_pop, lsb_pop;
  logic       arb_en, grant;
  cdb_src_e   grant_src, conflict_winner;

  // Ready uses registered occupancy: a same-cycle pop never frees a slot.
  assign rs_ready_out  = !rst_in && rdy_in && !rollback_in && !rs_full;
  assign lsb_ready_out = !rst_in && rdy_in && !rollback_in && !lsb_full;
  assign rs_push       = rs_valid_in && rs_ready_out;
  assign lsb_push      = lsb_valid_in && lsb_ready_out;

  always_comb begin
    rs_push_data           = '0;
    rs_push_data.rob_index = rs_rob_index_in;
    rs_push_data.value     = rs_value_in;
    rs_push_data.next_pc   = rs_next_pc_in;
    lsb_push_data           = '0;
    lsb_push_data.rob_index = lsb_rob_index_in;
    lsb_push_data.value     = lsb_value_in;
  end

  cdb_src_fifo #(.FIFO_DEPTH_LOG(FIFO_DEPTH_LOG)) u_rs_fifo (
    .clk       (clk_in),
    .rst       (rst_in),
    .en        (rdy_in),
    .flush     (rollback_in),
    .push      (rs_push),
    .pop       (rs_pop),
    .push_data (rs_push_data),
    .head      (rs_head),
    .empty     (rs_empty),
    .full      (rs_full)
  );

  cdb_src_fifo #(.FIFO_DEPTH_LOG(FIFO_DEPTH_LOG)) u_lsb_fifo (
    .clk       (clk_in),
    .rst       (rst_in),
    .en        (rdy_in),
    .flush     (rollback_in),
    .push      (lsb_push),
    .pop       (lsb_pop),
    .push_data (lsb_push_data),
    .head      (lsb_head),
    .empty     (lsb_empty),
    .full      (lsb_full)
  );

`ifdef CDB_ARB_LSB_PRIO_EN
  assign conflict_winner = SRC_LSB;
`else
  cdb_src_e prio_q;

  // After a grant the other source is favoured on the next conflict.
  always_ff @(posedge clk_in) begin
    if (rst_in)     prio_q <= SRC_RS;
    else if (grant) prio_q <= (grant_src == SRC_RS) ? SRC_LSB : SRC_RS;
  end

  assign conflict_winner = prio_q;
`endif

  assign arb_en = !rst_in && rdy_in && !rollback_in;

  always_comb begin
    grant     = 1'b0;
    grant_src = SRC_RS;
    if (arb_en) begin
      if (!rs_empty && !lsb_empty) begin
        grant     = 1'b1;
        grant_src = conflict_winner;
      end else if (!rs_empty) begin
        grant     = 1'b1;
        grant_src = SRC_RS;
      end else if (!lsb_empty) begin
        grant     = 1'b1;
        grant_src = SRC_LSB;
      end
    end
  end

  assign rs_pop      = grant && (grant_src == SRC_RS);
  assign lsb_pop     = grant && (grant_src == SRC_LSB);
  assign grant_entry = (grant_src == SRC_LSB) ? lsb_head : rs_head;

  // Rollback suppresses the grant, so it lands here as cdb_en_out <= 0.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cdb_en_out        <= 1'b0;
      cdb_rob_index_out <= '0;
      cdb_value_out     <= '0;
      cdb_next_pc_out   <= '0;
      cdb_src_out       <= 1'b0;
    end else if (rdy_in) begin
      cdb_en_out <= grant;
      if (grant) begin
        cdb_rob_index_out <= grant_entry.rob_index;
        cdb_value_out     <= grant_entry.value;
        cdb_next_pc_out   <= grant_entry.next_pc;
        cdb_src_out       <= grant_src;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a vector table for reset, single requests
// and a full LSB FIFO, then sequences for interleaved traffic, rollback and
// a global-ready freeze.
module tb_cdb_arbiter;

  logic        clk_in;
  logic        rst_in, rdy_in, rollback_in;
  logic        rs_valid_in, rs_ready_out;
  logic [7:0]  rs_rob_index_in;
  logic [31:0] rs_value_in, rs_next_pc_in;
  logic        lsb_valid_in, lsb_ready_out;
  logic [7:0]  lsb_rob_index_in;
  logic [31:0] lsb_value_in;
  logic        cdb_en_out;
  logic [7:0]  cdb_rob_index_out;
  logic [31:0] cdb_value_out, cdb_next_pc_out;
  logic        cdb_src_out;

  int checks = 0;
  int errors = 0;

  cdb_arbiter #(
    .ADDR_WIDTH     (32),
    .ROB_WIDTH      (8),
    .FIFO_DEPTH_LOG (1)
  ) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .rdy_in            (rdy_in),
    .rollback_in       (rollback_in),
    .rs_valid_in       (rs_valid_in),
    .rs_ready_out      (rs_ready_out),
    .rs_rob_index_in   (rs_rob_index_in),
    .rs_value_in       (rs_value_in),
    .rs_next_pc_in     (rs_next_pc_in),
    .lsb_valid_in      (lsb_valid_in),
    .lsb_ready_out     (lsb_ready_out),
    .lsb_rob_index_in  (lsb_rob_index_in),
    .lsb_value_in      (lsb_value_in),
    .cdb_en_out        (cdb_en_out),
    .cdb_rob_index_out (cdb_rob_index_out),
    .cdb_value_out     (cdb_value_out),
    .cdb_next_pc_out   (cdb_next_pc_out),
    .cdb_src_out       (cdb_src_out)
  );

  initial clk_in = 1'b1;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        rst, rdy, rb;
    logic        rs_v;
    logic [7:0]  rs_rob;
    logic [31:0] rs_val, rs_pc;
    logic        lsb_v;
    logic [7:0]  lsb_rob;
    logic [31:0] lsb_val;
    logic        exp_rs_rdy, exp_lsb_rdy;
    int          chk;  // 0: ready only, 1: + cdb_en, 2: + payload
    logic        exp_en;
    logic [7:0]  exp_rob;
    logic [31:0] exp_val, exp_pc;
    logic        exp_src;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_in(input logic rst, input logic rdy, input logic rb,
                          input logic rs_v, input logic [7:0] rs_rob,
                          input logic [31:0] rs_val, input logic [31:0] rs_pc,
                          input logic lsb_v, input logic [7:0] lsb_rob,
                          input logic [31:0] lsb_val);
    rst_in           = rst;
    rdy_in           = rdy;
    rollback_in      = rb;
    rs_valid_in      = rs_v;
    rs_rob_index_in  = rs_rob;
    rs_value_in      = rs_val;
    rs_next_pc_in    = rs_pc;
    lsb_valid_in     = lsb_v;
    lsb_rob_index_in = lsb_rob;
    lsb_value_in     = lsb_val;
  endtask

  task automatic set_in(input int i, input logic rst, input logic rs_v, input logic [7:0] rs_rob,
                        input logic [31:0] rs_val, input logic [31:0] rs_pc,
                        input logic lsb_v, input logic [7:0] lsb_rob, input logic [31:0] lsb_val);
    vecs[i].rst = rst;   vecs[i].rdy = 1'b1;  vecs[i].rb = 1'b0;
    vecs[i].rs_v = rs_v; vecs[i].rs_rob = rs_rob; vecs[i].rs_val = rs_val; vecs[i].rs_pc = rs_pc;
    vecs[i].lsb_v = lsb_v; vecs[i].lsb_rob = lsb_rob; vecs[i].lsb_val = lsb_val;
  endtask

  task automatic set_exp(input int i, input logic rs_rdy, input logic lsb_rdy, input int chk,
                         input logic en, input logic [7:0] rob, input logic [31:0] val,
                         input logic [31:0] pc, input logic src);
    vecs[i].exp_rs_rdy = rs_rdy; vecs[i].exp_lsb_rdy = lsb_rdy; vecs[i].chk = chk;
    vecs[i].exp_en = en; vecs[i].exp_rob = rob; vecs[i].exp_val = val;
    vecs[i].exp_pc = pc; vecs[i].exp_src = src;
  endtask

  task automatic next_cycle();
    @(posedge clk_in);
    #1;
  endtask

  logic [72:0] obs [16];
  int          got, r_sent, l_sent;
  logic        rs_drop, lsb_drop, rs_acc, lsb_acc;
  logic        es;
  int          et;

  initial begin
    // ---------------- vector table ----------------
    for (int i = 0; i < NVEC; i++) begin
      set_in(i, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0, 8'h00, 32'h0);
      set_exp(i, 1'b1, 1'b1, 1, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0);
    end
    // reset held three cycles, then idle
    for (int i = 0; i < 3; i++) set_in(i, 1'b1, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0, 8'h00, 32'h0);
    set_exp(0, 1'b0, 1'b0, 0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0);
    set_exp(1, 1'b0, 1'b0, 2, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0);
    set_exp(2, 1'b0, 1'b0, 2, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0);
    set_exp(3, 1'b1, 1'b1, 2, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0);
    // single RS request: broadcast two cycles later, for one cycle
    set_in(4, 1'b0, 1'b1, 8'd5, 32'hDEADBEEF, 32'h1004, 1'b0, 8'h00, 32'h0);
    set_exp(6, 1'b1, 1'b1, 2, 1'b1, 8'd5, 32'hDEADBEEF, 32'h1004, 1'b0);
    // single LSB request: next_pc broadcast as 0
    set_in(8, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b1, 8'h21, 32'hCAFEF00D);
    set_exp(10, 1'b1, 1'b1, 2, 1'b1, 8'h21, 32'hCAFEF00D, 32'h0, 1'b1);
    // LSB fills while RS wins the conflict; third LSB request waits a cycle
    set_in(11, 1'b0, 1'b1, 8'h41, 32'h41, 32'h4100, 1'b1, 8'h31, 32'h31);
    set_in(12, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b1, 8'h32, 32'h32);
    set_in(13, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b1, 8'h33, 32'h33);
    set_in(14, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b1, 8'h33, 32'h33);
    set_exp(13, 1'b1, 1'b0, 2, 1'b1, 8'h41, 32'h41, 32'h4100, 1'b0);
    set_exp(14, 1'b1, 1'b1, 2, 1'b1, 8'h31, 32'h31, 32'h0, 1'b1);
    set_exp(15, 1'b1, 1'b1, 2, 1'b1, 8'h32, 32'h32, 32'h0, 1'b1);
    set_exp(16, 1'b1, 1'b1, 2, 1'b1, 8'h33, 32'h33, 32'h0, 1'b1);

    for (int i = 0; i < NVEC; i++) begin
      drive_in(vecs[i].rst, vecs[i].rdy, vecs[i].rb, vecs[i].rs_v, vecs[i].rs_rob,
               vecs[i].rs_val, vecs[i].rs_pc, vecs[i].lsb_v, vecs[i].lsb_rob, vecs[i].lsb_val);
      @(negedge clk_in);
      check($sformatf("v%0d rs_ready", i), 128'(rs_ready_out), 128'(vecs[i].exp_rs_rdy));
      check($sformatf("v%0d lsb_ready", i), 128'(lsb_ready_out), 128'(vecs[i].exp_lsb_rdy));
      if (vecs[i].chk >= 1)
        check($sformatf("v%0d cdb_en", i), 128'(cdb_en_out), 128'(vecs[i].exp_en));
      if (vecs[i].chk >= 2) begin
        check($sformatf("v%0d cdb_rob", i), 128'(cdb_rob_index_out), 128'(vecs[i].exp_rob));
        check($sformatf("v%0d cdb_value", i), 128'(cdb_value_out), 128'(vecs[i].exp_val));
        check($sformatf("v%0d cdb_pc", i), 128'(cdb_next_pc_out), 128'(vecs[i].exp_pc));
        check($sformatf("v%0d cdb_src", i), 128'(cdb_src_out), 128'(vecs[i].exp_src));
      end
      next_cycle();
    end

    // ---------------- interleaved traffic: 6 RS + 6 LSB ----------------
    got = 0; r_sent = 0; l_sent = 0; rs_drop = 1'b0; lsb_drop = 1'b0;
    for (int cyc = 0; cyc < 60 && got < 12; cyc++) begin
      drive_in(1'b0, 1'b1, 1'b0,
               r_sent < 6, 8'(r_sent + 1), 32'h1000_0000 + 32'(r_sent + 1), 32'h2000 + 32'(4 * (r_sent + 1)),
               l_sent < 6, 8'(l_sent + 11), 32'h3000_0000 + 32'(l_sent + 11));
      @(negedge clk_in);
      if (rs_valid_in && !rs_ready_out) rs_drop = 1'b1;
      if (lsb_valid_in && !lsb_ready_out) lsb_drop = 1'b1;
      rs_acc  = rs_valid_in && rs_ready_out;
      lsb_acc = lsb_valid_in && lsb_ready_out;
      if (cdb_en_out && got < 16) begin
        obs[got] = {cdb_src_out, cdb_rob_index_out, cdb_value_out, cdb_next_pc_out};
        got++;
      end
      next_cycle();
      if (rs_acc) r_sent++;
      if (lsb_acc) l_sent++;
    end
    if (got < 12) $display("FAIL stream timeout: got %0d broadcasts expected 12", got);
    check("stream count", 128'(got), 128'(12));
    for (int k = 0; k < 12 && k < got; k++) begin
`ifdef CDB_ARB_LSB_PRIO_EN
      if (k < 6) begin es = 1'b1; et = 11 + k; end
      else       begin es = 1'b0; et = k - 5;  end
`else
      es = (k % 2) == 1;
      et = es ? 11 + k / 2 : 1 + k / 2;
`endif
      check($sformatf("stream bcast %0d", k), 128'(obs[k]),
            128'({es, 8'(et),
                  es ? 32'h3000_0000 + 32'(et) : 32'h1000_0000 + 32'(et),
                  es ? 32'h0 : 32'h2000 + 32'(4 * et)}));
    end
    check("stream rs ready drop", 128'(rs_drop), 128'(1));
`ifndef CDB_ARB_LSB_PRIO_EN
    check("stream lsb ready drop", 128'(lsb_drop), 128'(1));
`endif
    drive_in(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0, 8'h00, 32'h0);
    @(negedge clk_in);
    check("stream no extra", 128'(cdb_en_out), 128'(0));
    next_cycle();

    // ---------------- rollback ----------------
    drive_in(1'b0, 1'b1, 1'b0, 1'b1, 8'h51, 32'h51, 32'h5100, 1'b1, 8'h61, 32'h61);
    next_cycle();
    drive_in(1'b0, 1'b1, 1'b0, 1'b1, 8'h52, 32'h52, 32'h5200, 1'b1, 8'h62, 32'h62);
    next_cycle();
    drive_in(1'b0, 1'b1, 1'b1, 1'b1, 8'h53, 32'h53, 32'h5300, 1'b1, 8'h63, 32'h63);
    @(negedge clk_in);
    check("rb rs_ready", 128'(rs_ready_out), 128'(0));
    check("rb lsb_ready", 128'(lsb_ready_out), 128'(0));
    check("rb prior bcast", 128'(cdb_en_out), 128'(1));
    next_cycle();
    drive_in(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0, 8'h00, 32'h0);
    @(negedge clk_in);
    check("rb after en", 128'(cdb_en_out), 128'(0));
    check("rb after rs_ready", 128'(rs_ready_out), 128'(1));
    check("rb after lsb_ready", 128'(lsb_ready_out), 128'(1));
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      check($sformatf("rb drained %0d", k), 128'(cdb_en_out), 128'(0));
      next_cycle();
    end

    // ---------------- rdy_in freeze ----------------
    drive_in(1'b0, 1'b1, 1'b0, 1'b1, 8'h71, 32'h7100, 32'h7104, 1'b1, 8'h81, 32'h8100);
    next_cycle();
    drive_in(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0, 8'h00, 32'h0);
    @(negedge clk_in);
    check("frz pre en", 128'(cdb_en_out), 128'(0));
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      drive_in(1'b0, 1'b0, 1'b0, 1'b1, 8'h72, 32'h7200, 32'h7204, 1'b0, 8'h00, 32'h0);
      @(negedge clk_in);
      check($sformatf("frz %0d bcast", k), 128'({cdb_en_out, cdb_src_out, cdb_rob_index_out, cdb_value_out}),
            128'({1'b1, 1'b1, 8'h81, 32'h8100}));
      check($sformatf("frz %0d ready", k), 128'({rs_ready_out, lsb_ready_out}), 128'(0));
      next_cycle();
    end
    drive_in(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0, 8'h00, 32'h0);
    @(negedge clk_in);
    check("frz resume held", 128'({cdb_en_out, cdb_src_out, cdb_rob_index_out}), 128'({1'b1, 1'b1, 8'h81}));
    next_cycle();
    @(negedge clk_in);
    check("frz resume next", 128'({cdb_en_out, cdb_src_out, cdb_rob_index_out, cdb_value_out, cdb_next_pc_out}),
          128'({1'b1, 1'b0, 8'h71, 32'h7100, 32'h7104}));
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_in);
      check($sformatf("frz tail %0d", k), 128'(cdb_en_out), 128'(0));
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
